// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared single-port memory bus between the arbiter and the memory
//
// Purpose: bundles the request/response signals of the shared memory port.
// Signals:
//   mem_req    arbiter -> memory  access request, fields below stable while high
//   mem_we     arbiter -> memory  1 = store, 0 = load
//   mem_ctrl   arbiter -> memory  access size/sign code
//   mem_addr   arbiter -> memory  access address
//   mem_wdata  arbiter -> memory  store data
//   mem_ready  memory -> arbiter  one-cycle completion strobe
//   mem_rdata  memory -> arbiter  read data, valid with mem_ready
// Modports: master (arbiter side), slave (memory side).
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_ctrl;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates instruction-fetch and data requests onto one memory port
//
// Purpose: serves one fetch or data request at a time on a shared single-port
// memory, data side first, with an 8-bit watchdog that completes a stalled
// access with zero data and err.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request and address (held until if_valid)
//   if_valid/if_rdata           one-cycle fetch completion, instruction word
//   dm_req/dm_we/dm_ctrl/
//   dm_addr/dm_wdata            data request fields (held until dm_valid)
//   dm_valid/dm_rdata           one-cycle data completion, load data (0 for stores)
//   mem                         shared memory bus (mem_port_arbiter_if.master)
//   err                         pulses with a valid when the access timed out
//   busy                        high whenever the FSM is not IDLE
// Configuration:
//   ARB_IF_STARVE_GUARD_EN      when defined, a fetch request waiting behind three
//                               consecutive data grants is granted next.
module mem_port_arbiter (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [63:0]               if_addr,
  output logic                      if_valid,
  output logic [31:0]               if_rdata,
  input  logic                      dm_req,
  input  logic                      dm_we,
  input  logic [2:0]                dm_ctrl,
  input  logic [63:0]               dm_addr,
  input  logic [63:0]               dm_wdata,
  output logic                      dm_valid,
  output logic [63:0]               dm_rdata,
  mem_port_arbiter_if.master        mem,
  output logic                      err,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The access times out on the cycle the watchdog would step from 254 to 255,
  // which is the 255th access cycle without mem_ready.
  localparam logic [7:0] WD_LAST = 8'd254;

  state_t      state_q;
  logic [7:0]  wd_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [2:0]  mem_ctrl_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic        if_valid_q;
  logic        dm_valid_q;
  logic [31:0] if_rdata_q;
  logic [63:0] dm_rdata_q;
  logic        err_q;

  logic        grant_if;
  logic        grant_dm;

`ifdef ARB_IF_STARVE_GUARD_EN
  logic [1:0]  starve_q;

  assign grant_if = if_req && (!dm_req || (starve_q == 2'd3));

  // Counts data grants taken while a fetch was waiting; any fetch grant or an
  // arbitration cycle without a fetch request restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 2'd0;
    end else if (state_q == IDLE) begin
      if (!if_req || grant_if) begin
        starve_q <= 2'd0;
      end else if (grant_dm) begin
        starve_q <= starve_q + 2'd1;
      end
    end
  end
`else
  assign grant_if = if_req && !dm_req;
`endif

  assign grant_dm = dm_req && !grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wd_q        <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_ctrl_q  <= 3'd0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 64'd0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The mem_* registers double as the latched request fields.
          if (grant_dm) begin
            state_q     <= DM_ACC;
            wd_q        <= 8'd0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_ctrl_q  <= dm_ctrl;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
          end else if (grant_if) begin
            state_q     <= IF_ACC;
            wd_q        <= 8'd0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_ctrl_q  <= 3'd0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= 64'd0;
          end
        end

        IF_ACC, DM_ACC: begin
          // mem_ready wins over a simultaneous timeout.
          if (mem.mem_ready || (wd_q == WD_LAST)) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            err_q     <= !mem.mem_ready;
            if (state_q == IF_ACC) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem.mem_ready ? mem.mem_rdata[31:0] : 32'd0;
            end else begin
              dm_valid_q <= 1'b1;
              dm_rdata_q <= (mem.mem_ready && !mem_we_q) ? mem.mem_rdata : 64'd0;
            end
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end

        DONE: begin
          state_q    <= IDLE;
          if_valid_q <= 1'b0;
          dm_valid_q <= 1'b0;
          err_q      <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_ctrl  = mem_ctrl_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign if_valid      = if_valid_q;
  assign if_rdata      = if_rdata_q;
  assign dm_valid      = dm_valid_q;
  assign dm_rdata      = dm_rdata_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE);

endmodule
